// File: rtl/int_exec_pkg.sv
// Shared widths, opcode encodings and FSM state type for the integer execution unit.
package int_exec_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SLL   = 4'd5;
  localparam logic [OPC_W-1:0] OP_SRL   = 4'd6;
  localparam logic [OPC_W-1:0] OP_SRA   = 4'd7;
  localparam logic [OPC_W-1:0] OP_SLT   = 4'd8;
  localparam logic [OPC_W-1:0] OP_SLTU  = 4'd9;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd10;
  localparam logic [OPC_W-1:0] OP_PASSB = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/int_alu.sv
// Single-cycle combinational ALU; MUL and reserved opcodes produce zero here.
module int_alu
  import int_exec_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;
  logic        [4:0]        shamt;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign shamt = rs2[4:0];

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:   result = rs1 + rs2;
      OP_SUB:   result = rs1 - rs2;
      OP_AND:   result = rs1 & rs2;
      OP_OR:    result = rs1 | rs2;
      OP_XOR:   result = rs1 ^ rs2;
      OP_SLL:   result = rs1 << shamt;
      OP_SRL:   result = rs1 >> shamt;
      OP_SRA:   result = rs1_s >>> shamt;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, (rs1_s < rs2_s)};
      OP_SLTU:  result = {{(DATA_W-1){1'b0}}, (rs1 < rs2)};
      OP_PASSB: result = rs2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/int_exec_unit.sv
// Integer execution unit: accepts one instruction, computes it (ALU or multi-cycle
// multiply), then arbitrates for the CDB and broadcasts tag/result for one cycle.
module int_exec_unit
  import int_exec_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs1_data,
  input  logic [DATA_W-1:0] issueque_rs2_data,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic [OPC_W-1:0]  issueque_opcode,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int CNT_W = 4;

  function automatic logic [DATA_W-1:0] mul_lo(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return a * b;
  endfunction

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    cnt_p1;
  logic [DATA_W-1:0]   opa_p1;
  logic [DATA_W-1:0]   opb_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic [DATA_W-1:0]   res_p1;
  logic                vld_p2;
  logic [TAG_W-1:0]    tag_p2;
  logic [DATA_W-1:0]   data_p2;
  logic [DATA_W-1:0]   alu_result;
  logic                accept;
  logic                is_mul_op;
  logic                mul_done;
  logic                bcast;

  int_alu u_alu (
    .opcode (issueque_opcode),
    .rs1    (issueque_rs1_data),
    .rs2    (issueque_rs2_data),
    .result (alu_result)
  );

  assign accept        = issueque_ready & (state_q == IDLE) & reset;
  assign is_mul_op     = (issueque_opcode == OP_MUL);
  assign mul_done      = (state_q == MUL) && (cnt_p1 == '0);
  assign bcast         = (state_q == RESULT) && cdb_grant;
  assign issueblk_done = accept;
  assign cdb_req       = reset & (state_q == RESULT);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issueque_ready) state_d = is_mul_op ? MUL : RESULT;
      MUL:     if (cnt_p1 == '0) state_d = RESULT;
      RESULT:  if (cdb_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_p1 <= '0;
    else if (accept && is_mul_op)
      cnt_p1 <= CNT_W'(MUL_LATENCY - 1);
    else if (state_q == MUL && cnt_p1 != '0)
      cnt_p1 <= cnt_p1 - 1'b1;
  end

  // Stage p1: capture operands/tag on accept; result from ALU or from the multiply
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p1 <= issueque_rs1_data;
      opb_p1 <= issueque_rs2_data;
      tag_p1 <= issueque_rd_tag;
      res_p1 <= alu_result;
    end else if (mul_done) begin
      res_p1 <= mul_lo(opa_p1, opb_p1);
    end
  end

  // Stage p2: bus outputs are zero whenever no broadcast is in flight
  always_ff @(posedge clk) begin
    if (!reset || !bcast) begin
      vld_p2  <= 1'b0;
      tag_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= 1'b1;
      tag_p2  <= tag_p1;
      data_p2 <= res_p1;
    end
  end

  assign cdb_valid = vld_p2;
  assign cdb_tag   = tag_p2;
  assign cdb_data  = data_p2;

endmodule

// File: tb/tb_int_exec_unit.sv
// Directed bench for int_exec_unit with hand-computed expected values.
module tb_int_exec_unit;

  logic        clk;
  logic        reset;
  logic        issueque_ready;
  logic [31:0] issueque_rs1_data;
  logic [31:0] issueque_rs2_data;
  logic [5:0]  issueque_rd_tag;
  logic [3:0]  issueque_opcode;
  logic        issueblk_done;
  logic        cdb_req;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  int total;
  int bad;

  int_exec_unit #(.MUL_LATENCY(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .issueque_ready    (issueque_ready),
    .issueque_rs1_data (issueque_rs1_data),
    .issueque_rs2_data (issueque_rs2_data),
    .issueque_rd_tag   (issueque_rd_tag),
    .issueque_opcode   (issueque_opcode),
    .issueblk_done     (issueblk_done),
    .cdb_req           (cdb_req),
    .cdb_grant         (cdb_grant),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag);
    issueque_ready    = rdy;
    issueque_opcode   = op;
    issueque_rs1_data = a;
    issueque_rs2_data = b;
    issueque_rd_tag   = tag;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cdb_grant = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 6'd3);
    repeat (3) tick();
    #1;
    total++;
    if ({issueblk_done, cdb_req, cdb_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got done/req/valid=%b want 000", {issueblk_done, cdb_req, cdb_valid});
    end
    total++;
    if (cdb_tag !== 6'h00 || cdb_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus got tag=%h data=%h want 00/00000000", cdb_tag, cdb_data);
    end
    issueque_ready = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    cdb_grant = 1'b1;
    drive(1'b1, 4'd0, 32'h5, 32'h7, 6'h12);
    #1;
    total++;
    if (issueblk_done !== 1'b1) begin
      bad++; $display("FAIL add_done got %b want 1", issueblk_done);
    end
    tick();
    issueque_ready = 1'b0;
    #1;
    total++;
    if ({cdb_req, cdb_valid, issueblk_done} !== 3'b100) begin
      bad++; $display("FAIL add_req_n1 got req/valid/done=%b want 100", {cdb_req, cdb_valid, issueblk_done});
    end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h12 || cdb_data !== 32'h0000000C) begin
      bad++;
      $display("FAIL add_bcast got v=%b tag=%h data=%h want 1/12/0000000c", cdb_valid, cdb_tag, cdb_data);
    end
    total++;
    if (cdb_req !== 1'b0) begin
      bad++; $display("FAIL add_req_n2 got %b want 0", cdb_req);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 6'h0 || cdb_data !== 32'h0) begin
      bad++;
      $display("FAIL add_clear got v=%b tag=%h data=%h want 0/00/00000000", cdb_valid, cdb_tag, cdb_data);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops  [10] = '{4'd1, 4'd8, 4'd9, 4'd7, 4'd13, 4'd11, 4'd5, 4'd6, 4'd2, 4'd4};
    logic [31:0] as   [10] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678,
                               32'h11111111, 32'h00000001, 32'h80000000, 32'hF0F0F0F0, 32'hFF00FF00};
    logic [31:0] bs   [10] = '{32'h1, 32'h1, 32'h1, 32'h4, 32'h9ABCDEF0,
                               32'hDEADBEEF, 32'h0000003F, 32'h00000004, 32'h0FF00FF0, 32'h0F0F0F0F};
    logic [5:0]  tags [10] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h3F, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09};
    logic [31:0] exps [10] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h0,
                               32'hDEADBEEF, 32'h80000000, 32'h08000000, 32'h00F000F0, 32'hF00FF00F};
    cdb_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], tags[i]);
      #1;
      total++;
      if (issueblk_done !== 1'b1) begin
        bad++; $display("FAIL alu%0d_done got %b want 1", i, issueblk_done);
      end
      tick();
      issueque_ready = 1'b0;
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== tags[i] || cdb_data !== exps[i]) begin
        bad++;
        $display("FAIL alu%0d_op%0d got v=%b tag=%h data=%h want 1/%h/%h",
                 i, ops[i], cdb_valid, cdb_tag, cdb_data, tags[i], exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    cdb_grant = 1'b1;
    drive(1'b1, 4'd10, 32'h00010000, 32'h00010001, 6'h2A);
    #1;
    total++;
    if (issueblk_done !== 1'b1) begin
      bad++; $display("FAIL mul_done got %b want 1", issueblk_done);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if ({issueblk_done, cdb_req, cdb_valid} !== 3'b000) begin
        bad++; $display("FAIL mul_busy_n%0d got done/req/valid=%b want 000", c, {issueblk_done, cdb_req, cdb_valid});
      end
    end
    tick();
    total++;
    if ({issueblk_done, cdb_req} !== 2'b01) begin
      bad++; $display("FAIL mul_req_n4 got done/req=%b want 01", {issueblk_done, cdb_req});
    end
    tick();
    issueque_ready = 1'b0;
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h2A || cdb_data !== 32'h00010000) begin
      bad++;
      $display("FAIL mul_bcast got v=%b tag=%h data=%h want 1/2a/00010000", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  task automatic test_grant_hold();
    cdb_grant = 1'b0;
    drive(1'b1, 4'd0, 32'h3, 32'h4, 6'h07);
    tick();
    drive(1'b1, 4'd4, 32'h000000F0, 32'h000000FF, 6'h09);
    for (int c = 1; c <= 10; c++) begin
      #1;
      total++;
      if ({cdb_req, issueblk_done, cdb_valid} !== 3'b100) begin
        bad++; $display("FAIL hold_c%0d got req/done/valid=%b want 100", c, {cdb_req, issueblk_done, cdb_valid});
      end
      tick();
    end
    total++;
    if (dut.res_p1 !== 32'h7 || cdb_req !== 1'b1) begin
      bad++; $display("FAIL hold_stable got req=%b res=%h want 1/00000007", cdb_req, dut.res_p1);
    end
    cdb_grant = 1'b1;
    tick();
    #1;
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h07 || cdb_data !== 32'h7 || issueblk_done !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got v=%b tag=%h data=%h done=%b want 1/07/00000007/1",
               cdb_valid, cdb_tag, cdb_data, issueblk_done);
    end
    tick();
    issueque_ready = 1'b0;
    #1;
    total++;
    if (cdb_valid !== 1'b0 || cdb_req !== 1'b1) begin
      bad++; $display("FAIL hold_single_pulse got v=%b req=%b want 0/1", cdb_valid, cdb_req);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h09 || cdb_data !== 32'h0000000F) begin
      bad++;
      $display("FAIL hold_next got v=%b tag=%h data=%h want 1/09/0000000f", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    cdb_grant = 1'b1;
    drive(1'b1, 4'd0, 32'h100, 32'h1, 6'h11);
    tick();
    drive(1'b1, 4'd1, 32'h100, 32'h1, 6'h22);
    #1;
    total++;
    if ({issueblk_done, cdb_req} !== 2'b01) begin
      bad++; $display("FAIL b2b_gap got done/req=%b want 01", {issueblk_done, cdb_req});
    end
    tick();
    total++;
    if (issueblk_done !== 1'b1 || cdb_valid !== 1'b1 || cdb_data !== 32'h101 || cdb_tag !== 6'h11) begin
      bad++;
      $display("FAIL b2b_first got done=%b v=%b tag=%h data=%h want 1/1/11/00000101",
               issueblk_done, cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    issueque_ready = 1'b0;
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'h0FF || cdb_tag !== 6'h22) begin
      bad++; $display("FAIL b2b_second got v=%b tag=%h data=%h want 1/22/000000ff", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    cdb_grant = 1'b1;
    drive(1'b1, 4'd10, 32'h3, 32'h5, 6'h15);
    tick();
    issueque_ready = 1'b0;
    tick();
    reset = 1'b0;
    issueque_ready = 1'b1;
    #1;
    total++;
    if ({issueblk_done, cdb_req} !== 2'b00) begin
      bad++; $display("FAIL rst_mul_comb got done/req=%b want 00", {issueblk_done, cdb_req});
    end
    tick();
    issueque_ready = 1'b0;
    total++;
    if ({issueblk_done, cdb_req, cdb_valid} !== 3'b000 || cdb_tag !== 6'h0 || cdb_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_mul_outputs got done/req/valid=%b tag=%h data=%h want 000/00/00000000",
               {issueblk_done, cdb_req, cdb_valid}, cdb_tag, cdb_data);
    end
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_valid !== 1'b0 || cdb_req !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_mul_no_bcast got %0d active cycles want 0", seen);
    end
    drive(1'b1, 4'd0, 32'h100, 32'h23, 6'h21);
    #1;
    total++;
    if (issueblk_done !== 1'b1) begin
      bad++; $display("FAIL rst_add_done got %b want 1", issueblk_done);
    end
    tick();
    issueque_ready = 1'b0;
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'h21 || cdb_data !== 32'h123) begin
      bad++;
      $display("FAIL rst_add_bcast got v=%b tag=%h data=%h want 1/21/00000123", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    cdb_grant = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 6'h0);
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_grant_hold();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_exec_unit.md
# int_exec_unit

Integer execution block sitting downstream of the integer reservation station. It accepts one issued instruction at a time from the issue queue, handshakes acceptance with `issueblk_done`, and computes the result (single-cycle ALU ops, or a multi-cycle multiply). It then requests the common data bus and, once granted, broadcasts `cdb_tag`/`cdb_data`/`cdb_valid`, which are consumed by the reservation stations and the ROB.

## Interface
Parameters:
- `MUL_LATENCY`, default 3: cycles spent in the multiply state; legal range 1..15.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low: state clears on a rising edge while `reset`=0.
- `issueque_ready`  in  1  issue queue presents a valid instruction.
- `issueque_rs1_data`  in  32  operand A.
- `issueque_rs2_data`  in  32  operand B; shifts use bits [4:0].
- `issueque_rd_tag`  in  6  destination tag.
- `issueque_opcode`  in  4  operation code.
- `issueblk_done`  out  1  instruction accepted this cycle; the queue dequeues on this.
- `cdb_req`  out  1  result pending and the unit requests the CDB.
- `cdb_grant`  in  1  arbiter grant; sampled only while `cdb_req`=1.
- `cdb_valid`  out  1  broadcast strobe, one cycle per result.
- `cdb_tag`  out  6  broadcast tag; 0 when `cdb_valid`=0.
- `cdb_data`  out  32  broadcast result; 0 when `cdb_valid`=0.

## Operation
- FSM states:
  - IDLE: accepting instructions.
  - MUL: multiply in progress.
  - RESULT: result held, `cdb_req`=1.
- `issueblk_done` = `issueque_ready` & (state==IDLE) & `reset`. This is combinational. Accept happens on the edge where it is 1, and operands, tag and opcode are captured on that edge.
- Accepting an ALU op (0–9, 11–15): the result is computed from the live inputs and registered on the accept edge. Next state is RESULT.
- Accepting MUL (10): operands are captured and the counter loads `MUL_LATENCY`-1. Next state is MUL.
  - In MUL, the counter decrements each cycle.
  - When the counter is 0, the product low 32 bits are registered and the state moves to RESULT.
- RESULT with `cdb_grant`=1:
  - `cdb_valid`/`cdb_tag`/`cdb_data` are registered on that edge, so they are high for the following cycle only.
  - The state returns to IDLE on the same edge.
- RESULT with `cdb_grant`=0: hold indefinitely. No new accepts are made, `cdb_req` stays 1, and the held result is unchanged.
- `cdb_valid` self-clears after one cycle. The bus outputs return to 0.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed, result 0/1), 9 SLTU.
  - 10 MUL (low 32 bits, unsigned/signed identical).
  - 11 PASSB (result = rs2).
  - 12–15 reserved: result 0, still broadcast with the tag.
- Arithmetic is modulo 2^32; carries and overflow are discarded.
- `cdb_grant` while `cdb_req`=0 is ignored.
- Reset (`reset`=0 at an edge), including mid-multiply or mid-RESULT:
  - State becomes IDLE and the counter becomes 0.
  - `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0.
  - The pending result is discarded.
  - `issueblk_done` and `cdb_req` are 0 while `reset`=0.

## Timing
- Reset values: `issueblk_done`=0, `cdb_req`=0, `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0.
- ALU op accepted in cycle N, with grant available immediately:
  - `cdb_req`=1 in N+1.
  - `cdb_valid`=1 in N+2.
  - Next accept possible in N+2.
- MUL accepted in cycle N:
  - MUL state occupies N+1..N+`MUL_LATENCY`.
  - `cdb_req`=1 from N+`MUL_LATENCY`+1.
  - `cdb_valid` one cycle after the grant.
- Back-to-back throughput: one instruction per 2 cycles (ALU, immediate grant).
- The accept in cycle N+2 can overlap the `cdb_valid` of the previous result. This is legal.

## Structure
- Package `int_exec_pkg` holds:
  - the opcode localparams (`OP_ADD` … `OP_PASSB`);
  - the FSM state enum (IDLE/MUL/RESULT);
  - the widths DATA_W=32, TAG_W=6, OPC_W=4.
- Sub-module `int_alu`: purely combinational, covering opcodes other than MUL.
- The multiply, the counter and the FSM stay in `int_exec_unit`.

## Test plan
- ADD with rs1=0x0000_0005, rs2=0x0000_0007, tag=0x12, grant held at 1 → `issueblk_done` in N, `cdb_req` in N+1, and `cdb_valid`=1 with tag 0x12, data 0x0000_000C in N+2 for exactly one cycle.
- SUB 0x0 − 0x1 → data 0xFFFF_FFFF. SLT with 0xFFFF_FFFF vs 0x1 → 1. SLTU with the same operands → 0. SRA 0x8000_0000 by 4 → 0xF800_0000.
- MUL 0x0001_0000 × 0x0001_0001, `MUL_LATENCY`=3 → `cdb_req` first in N+4, data 0x0001_0000. `issueque_ready` held at 1 gives no second `issueblk_done` before the grant.
- Grant withheld for 10 cycles in RESULT → `cdb_req` stays 1, data stable, no accepts. A grant on cycle 11 gives one `cdb_valid` pulse, and an accept occurs the next cycle.
- `reset`=0 during MUL cycle 2 → all outputs 0 after that edge and no broadcast ever appears. A new ADD after reset is released completes normally.
- Opcode 13 with tag 0x3F → broadcast tag 0x3F, data 0x0000_0000.
